// File: rtl/servo_slew_driver.sv
// servo_slew_driver: 50 Hz servo PWM generator for one joint. The commanded
// position walks toward the (clamped) target by at most STEP per frame, and
// FLAG rises once the position has held at target for SETTLE_FRAMES frames.
module servo_slew_driver #(
    parameter int unsigned FRAME_LEN     = 2000000,
    parameter int unsigned MIN_PULSE     = 50000,
    parameter int unsigned POS_MAX       = 200000,
    parameter int unsigned STEP          = 2000,
    parameter int unsigned SETTLE_FRAMES = 5,
    parameter int unsigned RESET_POS     = 113100
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [19:0] DESIRED,
    output logic        PWM,
    output logic        FLAG,
    output logic [19:0] POSITION,
    output logic        FRAME_TICK
);

    localparam int unsigned      SW             = $clog2(SETTLE_FRAMES + 1);
    localparam logic [20:0]      LP_FRAME_LAST  = 21'(FRAME_LEN - 1);
    localparam logic [20:0]      LP_MIN_PULSE   = 21'(MIN_PULSE);
    localparam logic [19:0]      LP_POS_MAX     = 20'(POS_MAX);
    localparam logic [19:0]      LP_STEP        = 20'(STEP);
    localparam logic [19:0]      LP_RESET_POS   = 20'(RESET_POS);
    localparam logic [SW-1:0]    LP_SETTLE_LAST = SW'(SETTLE_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_SLEW,
        ST_SETTLE,
        ST_DONE
    } state_t;

    logic [20:0]   r_cnt;
    logic [19:0]   r_pos;
    state_t        r_state;
    logic [SW-1:0] r_settle;
    logic          r_flag;
    logic          r_pwm;

    logic          w_bnd;
    logic [19:0]   w_tgt;
    logic [19:0]   w_diff;
    logic [19:0]   w_pos_nxt;
    logic [20:0]   w_pulse_len;

    assign w_bnd       = (r_cnt == LP_FRAME_LAST);
    // MIN_PULSE + POS_MAX < FRAME_LEN, so the pulse always ends inside the frame
    assign w_pulse_len = LP_MIN_PULSE + {1'b0, r_pos};

    // Free-running frame counter, 0..FRAME_LEN-1
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (w_bnd) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 21'd1;
        end
    end

    // Clamp the target and take one bounded step toward it; the step size is
    // decided on the absolute difference so pos - STEP can never wrap
    always_comb begin
        w_tgt     = (DESIRED > LP_POS_MAX) ? LP_POS_MAX : DESIRED;
        w_diff    = '0;
        w_pos_nxt = w_tgt;
        if (w_tgt > r_pos) begin
            w_diff = w_tgt - r_pos;
            if (w_diff > LP_STEP) begin
                w_pos_nxt = r_pos + LP_STEP;
            end
        end else if (w_tgt < r_pos) begin
            w_diff = r_pos - w_tgt;
            if (w_diff > LP_STEP) begin
                w_pos_nxt = r_pos - LP_STEP;
            end
        end
    end

    // Registered PWM: high for exactly MIN_PULSE + pos clocks each frame
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (r_cnt < w_pulse_len);
        end
    end

    // Position update and settle FSM, both advanced only at the frame boundary
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_SETTLE;
            r_pos    <= LP_RESET_POS;
            r_settle <= '0;
            r_flag   <= 1'b0;
        end else if (w_bnd) begin
            r_pos <= w_pos_nxt;
            case (r_state)
                ST_SLEW: begin
                    if (w_pos_nxt == w_tgt) begin
                        r_state  <= ST_SETTLE;
                        r_settle <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (w_tgt != r_pos) begin
                        r_state <= ST_SLEW;
                    end else if (r_settle == LP_SETTLE_LAST) begin
                        r_state <= ST_DONE;
                        r_flag  <= 1'b1;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                ST_DONE: begin
                    if (w_tgt != r_pos) begin
                        r_state <= ST_SLEW;
                        r_flag  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_SLEW;
                    r_flag  <= 1'b0;
                end
            endcase
        end
    end

    assign PWM        = r_pwm;
    assign FLAG       = r_flag;
    assign POSITION   = r_pos;
    assign FRAME_TICK = w_bnd;

endmodule

// File: tb/tb_servo_slew_driver.sv
// tb_servo_slew_driver: directed frames with hand-computed expectations.
// Each queued entry is {PWM high clocks in the frame, POSITION after its
// boundary, FLAG after its boundary}; the monitor pops one per FRAME_TICK.
module tb_servo_slew_driver;

    logic        CLK;
    logic        RST_N;
    logic [19:0] DESIRED;
    logic        PWM;
    logic        FLAG;
    logic [19:0] POSITION;
    logic        FRAME_TICK;

    typedef struct {
        int hi;
        int pos;
        int flag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    servo_slew_driver #(
        .FRAME_LEN    (1000),
        .MIN_PULSE    (100),
        .POS_MAX      (500),
        .STEP         (50),
        .SETTLE_FRAMES(2),
        .RESET_POS    (0)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .DESIRED   (DESIRED),
        .PWM       (PWM),
        .FLAG      (FLAG),
        .POSITION  (POSITION),
        .FRAME_TICK(FRAME_TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int hi, input int pos, input int flag);
        exp_t e;
        e.hi   = hi;
        e.pos  = pos;
        e.flag = flag;
        q.push_back(e);
    endtask

    // Returns at the negedge of the cnt=0 cycle that follows the last popped frame
    task automatic drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        check({"drain_", tag}, q.size(), 0);
        q.delete();
    endtask

    // Monitor: count PWM-high clocks per frame, compare at each boundary
    initial begin
        int   hcnt = 0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                hcnt = 0;
            end else begin
                if (PWM) hcnt++;
                if (FRAME_TICK) begin
                    @(posedge CLK);
                    #1;
                    if (q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("pwm_high_clocks", hcnt, e.hi);
                        check("position", int'(POSITION), e.pos);
                        check("flag", int'(FLAG), e.flag);
                    end
                    hcnt = 0;
                end
            end
        end
    end

    initial begin
        int n;
        RST_N   = 1'b0;
        DESIRED = 20'd200;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_pwm", int'(PWM), 0);
        check("rst_flag", int'(FLAG), 0);
        check("rst_tick", int'(FRAME_TICK), 0);
        check("rst_position", int'(POSITION), 0);

        // Slew 0 -> 200 from reset
        push(100, 50, 0);  push(150, 100, 0); push(200, 150, 0);
        push(250, 200, 0); push(300, 200, 0); push(300, 200, 1);
        @(negedge CLK);
        RST_N = 1'b1;
        drain("slew");

        // Retarget to 150 mid-frame while DONE, plus an invisible glitch
        push(300, 150, 0); push(250, 150, 0); push(250, 150, 0); push(250, 150, 1);
        repeat (500) @(negedge CLK);
        DESIRED = 20'd150;
        repeat (600) @(negedge CLK);
        DESIRED = 20'd400;
        repeat (200) @(negedge CLK);
        DESIRED = 20'd150;
        drain("retarget");

        // Back to 200, count one settled frame, then restart with 260
        DESIRED = 20'd200;
        push(250, 200, 0); push(300, 200, 0); push(300, 200, 0);
        drain("to200");
        DESIRED = 20'd260;
        push(300, 250, 0); push(350, 260, 0); push(360, 260, 0); push(360, 260, 1);
        drain("settle_restart");

        // Down to 0: final partial step of 10 must not underflow
        DESIRED = 20'd0;
        push(360, 210, 0); push(310, 160, 0); push(260, 110, 0); push(210, 60, 0);
        push(160, 10, 0);  push(110, 0, 0);   push(100, 0, 0);   push(100, 0, 1);
        drain("to0");

        // Partial step: 0 -> 120
        DESIRED = 20'd120;
        push(100, 50, 0); push(150, 100, 0); push(200, 120, 0);
        push(220, 120, 0); push(220, 120, 1);
        drain("partial");

        // Clamp: 900 saturates at 500
        DESIRED = 20'd900;
        push(220, 170, 0); push(270, 220, 0); push(320, 270, 0); push(370, 320, 0);
        push(420, 370, 0); push(470, 420, 0); push(520, 470, 0); push(570, 500, 0);
        push(600, 500, 0); push(600, 500, 1);
        drain("clamp");

        // Targets that clamp to the current position leave DONE alone
        DESIRED = 20'd700;
        push(600, 500, 1);
        drain("clamp700");
        DESIRED = 20'hFFFFF;
        push(600, 500, 1);
        drain("clampmax");

        // Async reset at cnt=37 with PWM high
        repeat (37) @(posedge CLK);
        #1;
        check("pre_rst_pwm", int'(PWM), 1);
        check("pre_rst_flag", int'(FLAG), 1);
        check("pre_rst_position", int'(POSITION), 500);
        RST_N = 1'b0;
        #1;
        check("async_pwm", int'(PWM), 0);
        check("async_flag", int'(FLAG), 0);
        check("async_tick", int'(FRAME_TICK), 0);
        check("async_position", int'(POSITION), 0);
        repeat (3) @(negedge CLK);
        push(100, 50, 0); push(150, 100, 0);
        RST_N = 1'b1;
        // cnt reaches 999 on the 999th edge: the tick is the 1000th clock of the frame
        n = 0;
        while (n < 3000) begin
            @(posedge CLK);
            n++;
            #1;
            if (FRAME_TICK) break;
        end
        check("first_tick_edges", n, 999);
        @(posedge CLK);
        #1;
        check("tick_one_cycle", int'(FRAME_TICK), 0);
        drain("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
